// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: pipeline constants and bus layouts shared by fetch and decode
//   RESET_PC        first fetch address after reset
//   IF_TO_ID_BUS_W  width of {pc, inst} toward decode
//   BR_BUS_W        width of {br_taken, br_target} from decode
package fetch_stage_pkg;
  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam int IF_TO_ID_BUS_W = 64;
  localparam int BR_BUS_W = 33;
  localparam int IF_BUS_INST_LSB = 0;
  localparam int IF_BUS_PC_LSB = 32;
  localparam int BR_BUS_TARGET_LSB = 0;
  localparam int BR_BUS_TAKEN_BIT = 32;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_to_id_t;
  typedef struct packed {
    logic taken;
    logic [31:0] target;
  } br_bus_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: SRAM-like instruction port
//   master (fetch): req, wr, size, wstrb, addr, wdata out; addr_ok, data_ok, rdata in
//   slave (memory): the mirror image
interface fetch_stage_if;
  logic req;
  logic wr;
  logic [1:0] size;
  logic [3:0] wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic addr_ok;
  logic data_ok;
  logic [31:0] rdata;
  modport master (output req, wr, size, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave (input req, wr, size, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/fetch_hold_reg.sv
// fetch_hold_reg: one-entry hold register with set/clear and a valid flag
//   clk, resetn (sync, active-low), set loads d and marks valid, clr drops valid
//   q holds the last loaded value; set wins over clr
module fetch_hold_reg #(
  parameter int W = 32
) (
  input  logic clk,
  input  logic resetn,
  input  logic set,
  input  logic clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic valid
);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      q <= '0;
      valid <= 1'b0;
    end else begin
      valid <= set | (valid & ~clr);
      if (set) q <= d;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with redirect buffering and wrong-path discard
//   clk, resetn (sync, active-low)
//   ID_allow_in / IF_to_ID_valid / IF_to_ID_bus {pc, inst}: handshake toward decode
//   ID_to_IF_bus {br_taken, br_target}: redirect from decode
//   inst_sram: SRAM-like instruction port (master side)
//   fetch_stall_cnt: cycles IF holds a request awaiting data, only with FETCH_STALL_CNT_EN
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic ID_allow_in,
  output logic IF_to_ID_valid,
  output logic [IF_TO_ID_BUS_W-1:0] IF_to_ID_bus,
  input  logic [BR_BUS_W-1:0] ID_to_IF_bus,
`ifdef FETCH_STALL_CNT_EN
  output logic [31:0] fetch_stall_cnt,
`endif
  fetch_stage_if.master inst_sram
);
  br_bus_t br;
  if_to_id_t out;
  logic if_valid, if_ready_go, if_allow_in, hs, to_id, discard;
  logic inst_buf_valid, br_buf_valid;
  logic [31:0] if_pc, nextpc, inst_buf, br_buf;
  assign br = ID_to_IF_bus;
  assign nextpc = br_buf_valid ? br_buf : br.taken ? br.target : if_pc + 32'd4;
  assign if_ready_go = inst_buf_valid | (inst_sram.data_ok & ~discard);
  assign if_allow_in = ~if_valid | (if_ready_go & ID_allow_in);
  assign hs = inst_sram.req & inst_sram.addr_ok;
  assign to_id = if_valid & if_ready_go & ID_allow_in;
  assign inst_sram.req = resetn & if_allow_in;
  assign inst_sram.wr = 1'b0;
  assign inst_sram.size = 2'd2;
  assign inst_sram.wstrb = 4'd0;
  assign inst_sram.addr = nextpc;
  assign inst_sram.wdata = 32'd0;
  assign IF_to_ID_valid = if_valid & if_ready_go;
  assign out.pc = if_pc;
  assign out.inst = inst_buf_valid ? inst_buf : inst_sram.rdata;
  assign IF_to_ID_bus = out;
  // A branch with the live request still in flight marks its response for dropping;
  // a response arriving in the branch cycle itself is simply not captured.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      if_valid <= 1'b0;
      if_pc <= RESET_PC - 32'd4;
      discard <= 1'b0;
    end else begin
      if_valid <= hs | (if_valid & ~br.taken & ~to_id);
      if (hs) if_pc <= nextpc;
      discard <= (br.taken & if_valid & ~if_ready_go) | (discard & ~inst_sram.data_ok);
    end
  end
  fetch_hold_reg #(.W(32)) u_inst_buf (
    .clk(clk),
    .resetn(resetn),
    .set(inst_sram.data_ok & ~discard & if_valid & ~ID_allow_in & ~br.taken),
    .clr(hs | br.taken | to_id),
    .d(inst_sram.rdata),
    .q(inst_buf),
    .valid(inst_buf_valid)
  );
  fetch_hold_reg #(.W(32)) u_br_buf (
    .clk(clk),
    .resetn(resetn),
    .set(br.taken & ~hs),
    .clr(hs),
    .d(br.target),
    .q(br_buf),
    .valid(br_buf_valid)
  );
`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!resetn) fetch_stall_cnt <= '0;
    else if (if_valid & ~if_ready_go) fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized traffic against a stream-level model
module tb_fetch_stage;
  import fetch_stage_pkg::*;
  logic clk = 1'b0;
  logic resetn, ID_allow_in, IF_to_ID_valid;
  logic [63:0] IF_to_ID_bus;
  logic [32:0] ID_to_IF_bus;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] fetch_stall_cnt;
`endif
  fetch_stage_if sram();
  fetch_stage dut (
    .clk(clk),
    .resetn(resetn),
    .ID_allow_in(ID_allow_in),
    .IF_to_ID_valid(IF_to_ID_valid),
    .IF_to_ID_bus(IF_to_ID_bus),
    .ID_to_IF_bus(ID_to_IF_bus),
`ifdef FETCH_STALL_CNT_EN
    .fetch_stall_cnt(fetch_stall_cnt),
`endif
    .inst_sram(sram)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] a;
    int rdy;
  } req_t;
  req_t q[$];
  int n_tests, n_fail, cyc, lat, n_del;
  logic k_rstn, k_allow, k_ok, k_br, pend;
  logic [31:0] k_tgt, exp_pc, nxt, tmp;
  logic s_req, s_valid;
  logic [31:0] s_addr;
  logic [63:0] s_bus;
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a == 32'h1c000008) ? 32'h02800421 : ({a[15:0], a[31:16]} ^ 32'h5a5a0f0f);
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  // One clock: apply knobs, play the slave, sample, update the expected fetch/delivery streams.
  task automatic cycle();
    logic hs, fire;
    logic [31:0] ea;
    @(negedge clk);
    resetn = k_rstn;
    ID_allow_in = k_allow;
    ID_to_IF_bus = {k_br, k_tgt};
    sram.addr_ok = k_ok;
    if (!k_rstn) q.delete();
    sram.data_ok = (q.size() > 0) && (q[0].rdy <= cyc);
    sram.rdata = sram.data_ok ? inst_of(q[0].a) : $urandom;
    #1;
    s_req = sram.req;
    s_addr = sram.addr;
    s_valid = IF_to_ID_valid;
    s_bus = IF_to_ID_bus;
    hs = s_req & k_ok;
    fire = s_valid & k_allow;
    if (!k_rstn) begin
      check("rst_req", s_req, 0);
      exp_pc = RESET_PC;
      nxt = RESET_PC;
      pend = 1'b0;
    end else begin
      if (hs) begin
        ea = (k_br && !pend) ? k_tgt : nxt;
        check("req_addr", s_addr, ea);
        check("outstanding_le_2", (q.size() - int'(sram.data_ok) + 1) <= 2, 1);
        nxt = ea + 32'd4;
        pend = 1'b0;
      end
      if (fire && !k_br) begin
        check("deliv_pc", s_bus[63:32], exp_pc);
        check("deliv_inst", s_bus[31:0], inst_of(exp_pc));
        exp_pc += 32'd4;
        n_del++;
      end
      if (k_br) begin
        exp_pc = k_tgt;
        if (!hs) begin
          nxt = k_tgt;
          pend = 1'b1;
        end
      end
    end
    if (sram.data_ok) void'(q.pop_front());
    if (hs) q.push_back('{s_addr, cyc + lat});
    cyc++;
    k_br = 1'b0;
  endtask
  task automatic reset_seq();
    k_rstn = 1'b0;
    k_br = 1'b0;
    cycle();
    cycle();
    check("rst_valid", s_valid, 0);
    k_rstn = 1'b1;
  endtask
  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; n_del = 0; lat = 1;
    k_rstn = 1'b0; k_allow = 1'b1; k_ok = 1'b1; k_br = 1'b0; k_tgt = '0;
    exp_pc = RESET_PC; nxt = RESET_PC; pend = 1'b0;
    resetn = 1'b0; ID_allow_in = 1'b0; ID_to_IF_bus = '0;
    sram.addr_ok = 1'b0; sram.data_ok = 1'b0; sram.rdata = '0;
    // 1: zero-wait streaming from reset
    reset_seq();
    cycle();
    check("t1_req0", s_req, 1);
    check("t1_addr0", s_addr, 32'h1c000000);
    check("t1_valid0", s_valid, 0);
    check("t1_consts", {sram.wr, sram.size, sram.wstrb, sram.wdata}, {1'b0, 2'd2, 4'd0, 32'd0});
    cycle();
    check("t1_addr1", s_addr, 32'h1c000004);
    check("t1_valid1", s_valid, 1);
    check("t1_pc1", s_bus[63:32], 32'h1c000000);
    cycle();
    check("t1_addr2", s_addr, 32'h1c000008);
    check("t1_pc2", s_bus[63:32], 32'h1c000004);
    // 2: decode stalls while 0x02800421 returns
    k_allow = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t2_noreq", s_req, 0);
      check("t2_valid", s_valid, 1);
      check("t2_inst", s_bus[31:0], 32'h02800421);
    end
    k_allow = 1'b1;
    cycle();
    check("t2_deliv_pc", s_bus[63:32], 32'h1c000008);
    check("t2_deliv_inst", s_bus[31:0], 32'h02800421);
    check("t2_next_addr", s_addr, 32'h1c00000c);
    // 3: branch over a slow outstanding request
    reset_seq();
    lat = 4;
    cycle();
    k_br = 1'b1; k_tgt = 32'h1c000100;
    cycle();
    check("t3_noreq", s_req, 0);
    cycle();
    check("t3_addr", s_addr, 32'h1c000100);
    for (int i = 0; i < 4; i++) begin
      check("t3_novalid", s_valid, 0);
      cycle();
    end
    check("t3_valid", s_valid, 1);
    check("t3_pc", s_bus[63:32], 32'h1c000100);
    lat = 1;
    // 4: branch while addr_ok is held low
    reset_seq();
    cycle();
    k_ok = 1'b0; k_br = 1'b1; k_tgt = 32'h1c000200;
    cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t4_addr_held", s_addr, 32'h1c000200);
      check("t4_novalid", s_valid, 0);
    end
    k_ok = 1'b1;
    cycle();
    check("t4_addr_acc", s_addr, 32'h1c000200);
    cycle();
    check("t4_valid", s_valid, 1);
    check("t4_pc", s_bus[63:32], 32'h1c000200);
    // 5: branch coincident with data_ok
    k_allow = 1'b0; k_br = 1'b1; k_tgt = 32'h1c000300;
    cycle();
    check("t5_noreq", s_req, 0);
    k_allow = 1'b1;
    cycle();
    check("t5_dropped", s_valid, 0);
    check("t5_addr", s_addr, 32'h1c000300);
    lat = 3;
    cycle();
    check("t5_valid", s_valid, 1);
    check("t5_pc", s_bus[63:32], 32'h1c000300);
    // 6: reset with a request in flight
    k_rstn = 1'b0;
    cycle();
    k_rstn = 1'b1;
    lat = 1;
    cycle();
    check("t6_valid_after_rst", s_valid, 0);
    check("t6_addr", s_addr, 32'h1c000000);
`ifdef FETCH_STALL_CNT_EN
    check("t6_stall_cnt", fetch_stall_cnt, 0);
`endif
    cycle();
    check("t6_valid", s_valid, 1);
    check("t6_pc", s_bus[63:32], 32'h1c000000);
    // random traffic; branches only where at most one response can become wrong-path
    n_del = 0;
    for (int i = 0; i < 4000; i++) begin
      k_ok = $urandom_range(0, 9) < 7;
      lat = $urandom_range(1, 3);
      k_allow = $urandom_range(0, 3) != 0;
      tmp = $urandom;
      k_tgt = {tmp[31:2], 2'b00};
      k_br = ($urandom_range(0, 15) == 0) && (q.size() <= 1) && !pend;
      cycle();
    end
    check("rand_progress", n_del > 300, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
